// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan driver and alarm sequencer.
// Segment patterns are active-low, bit6 = a ... bit0 = g.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b1100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;

  typedef enum logic [1:0] {
    ALARM_IDLE     = 2'd0,
    ALARM_RINGING  = 2'd1,
    ALARM_SILENCED = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/display_scan_driver_if.sv
// Bundle of value sources, mode controls and pin-side outputs of the scan driver.
// The master side feeds time/alarm/set values; the slave side is the driver itself.
interface display_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    one_second;
  logic [4*NUM_DIGITS-1:0] time_data;
  logic [4*NUM_DIGITS-1:0] alarm_data;
  logic [4*NUM_DIGITS-1:0] set_data;
  logic                    show_time;
  logic                    show_alarm;
  logic                    alarm_on;
  logic                    stop_alarm;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic [6:0]              segment_n;
  logic                    sound_alarm;

  modport master (
    output one_second, time_data, alarm_data, set_data,
    output show_time, show_alarm, alarm_on, stop_alarm, blink_mask,
    input  digit_en_n, segment_n, sound_alarm
  );

  modport slave (
    input  one_second, time_data, alarm_data, set_data,
    input  show_time, show_alarm, alarm_on, stop_alarm, blink_mask,
    output digit_en_n, segment_n, sound_alarm
  );

endinterface

// File: rtl/seg7_encoder.sv
// Combinational BCD to active-low seven-segment pattern; codes above 9 are blanked.
module seg7_encoder
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed seven-segment scan driver with set-mode blinking and an alarm
// sequencer (idle / ringing / silenced) that drives a registered buzzer output.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ALARM_SECS = 60
) (
  input  logic                   clk,
  input  logic                   reset,
  display_scan_driver_if.slave   disp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SEC_W = $clog2(ALARM_SECS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE  = PRE_W'(SCAN_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_LIMIT = SEC_W'(ALARM_SECS);

  logic [PRE_W-1:0]        presc_q;
  logic [IDX_W-1:0]        scan_idx_q;
  logic                    blink_phase_q;
  logic [NUM_DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
  logic [6:0]              segment_n_q, segment_n_d;

  logic [4*NUM_DIGITS-1:0] src;
  logic                    set_mode;
  logic [3:0]              nibble;
  logic                    blink_bit;
  logic [6:0]              enc_seg;

  alarm_state_e            state_q, state_d;
  logic [SEC_W-1:0]        sec_cnt_q, sec_cnt_d;
  logic                    sound_q, sound_d;
  logic                    match;

  // Source selection and per-slot digit pick; time outranks alarm, set mode otherwise.
  always_comb begin
    set_mode     = !disp.show_time && !disp.show_alarm;
    src          = disp.set_data;
    if (disp.show_time)
      src = disp.time_data;
    else if (disp.show_alarm)
      src = disp.alarm_data;
    nibble       = 4'h0;
    blink_bit    = 1'b0;
    digit_en_n_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        nibble          = src[4*i +: 4];
        blink_bit       = disp.blink_mask[i];
        digit_en_n_d[i] = 1'b0;
      end
    end
  end

  seg7_encoder u_encoder (
    .bcd_i   (nibble),
    .seg_n_o (enc_seg)
  );

  always_comb begin
    segment_n_d = enc_seg;
    if (set_mode && blink_phase_q && blink_bit)
      segment_n_d = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      scan_idx_q    <= '0;
      blink_phase_q <= 1'b0;
      digit_en_n_q  <= '1;
      segment_n_q   <= SEG_BLANK;
    end else begin
      if (presc_q == LAST_PRE) begin
        presc_q    <= '0;
        scan_idx_q <= (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      if (disp.one_second)
        blink_phase_q <= !blink_phase_q;
      digit_en_n_q <= digit_en_n_d;
      segment_n_q  <= segment_n_d;
    end
  end

  assign match = (disp.time_data == disp.alarm_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ALARM_IDLE;
      sec_cnt_q <= '0;
      sound_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      sound_q   <= sound_d;
    end
  end

  // Dropping alarm_on while ringing beats both stop and timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    case (state_q)
      ALARM_IDLE: begin
        if (disp.alarm_on && match) begin
          state_d   = disp.stop_alarm ? ALARM_SILENCED : ALARM_RINGING;
          sec_cnt_d = '0;
        end
      end
      ALARM_RINGING: begin
        if (!disp.alarm_on) begin
          state_d = ALARM_IDLE;
        end else if (disp.stop_alarm) begin
          state_d = ALARM_SILENCED;
        end else if (disp.one_second) begin
          sec_cnt_d = sec_cnt_q + 1'b1;
          if (sec_cnt_q + 1'b1 == SEC_LIMIT)
            state_d = ALARM_SILENCED;
        end
      end
      ALARM_SILENCED: begin
        if (!match || !disp.alarm_on)
          state_d = ALARM_IDLE;
      end
      default: state_d = ALARM_IDLE;
    endcase
  end

  always_comb begin
    sound_d = (state_d == ALARM_RINGING);
  end

  assign disp.digit_en_n  = digit_en_n_q;
  assign disp.segment_n   = segment_n_q;
  assign disp.sound_alarm = sound_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver: scanning, blinking, blank codes,
// alarm ring/timeout/stop/re-arm and asynchronous reset.
module tb_display_scan_driver;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  display_scan_driver_if #(.NUM_DIGITS(4)) dif ();
  display_scan_driver_if #(.NUM_DIGITS(4)) dif2 ();

  display_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .ALARM_SECS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (dif)
  );

  display_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(1), .ALARM_SECS(3)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .disp  (dif2)
  );

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100;
  localparam logic [6:0] P9 = 7'b0001100, PB = 7'b1111111;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_second();
    dif.one_second = 1'b1;
    step(1);
    dif.one_second = 1'b0;
    step(1);
  endtask

  // Bounded search for a given enabled digit on the slow instance.
  task automatic wait_digit(input int d, input string name);
    logic [3:0] exp;
    bit         found;
    exp   = ~(4'b0001 << d);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (dif.digit_en_n === exp) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: digit_en_n=%b never reached %b", name, dif.digit_en_n, exp);
    end
  endtask

  task automatic test_reset();
    dif.one_second = 0; dif.time_data = 16'h1234; dif.alarm_data = 16'h0000;
    dif.set_data = 16'h0000; dif.show_time = 1; dif.show_alarm = 0;
    dif.alarm_on = 0; dif.stop_alarm = 0; dif.blink_mask = 4'b0000;
    dif2.one_second = 0; dif2.time_data = 16'h1234; dif2.alarm_data = 16'h0000;
    dif2.set_data = 16'h0000; dif2.show_time = 1; dif2.show_alarm = 0;
    dif2.alarm_on = 0; dif2.stop_alarm = 0; dif2.blink_mask = 4'b0000;
    reset = 1'b1;
    #1;
    compared++;
    if (dif.digit_en_n !== 4'b1111 || dif.segment_n !== PB || dif.sound_alarm !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got en=%b seg=%b snd=%b want 1111 1111111 0",
               dif.digit_en_n, dif.segment_n, dif.sound_alarm);
    end
    step(2);
    reset = 1'b0;
    step(1);
    compared++;
    if (dif.digit_en_n !== 4'b1110 || dif.segment_n !== P4) begin
      mismatched++;
      $display("[TB] FAIL reset_first_clk: got en=%b seg=%b want 1110 %b",
               dif.digit_en_n, dif.segment_n, P4);
    end
  endtask

  task automatic test_scan();
    logic [6:0] segs [4];
    logic [3:0] exp_en;
    int         d;
    segs[0] = P4; segs[1] = P3; segs[2] = P2; segs[3] = P1;
    for (int c = 2; c <= 20; c++) begin
      step(1);
      d      = ((c - 1) / 4) % 4;
      exp_en = ~(4'b0001 << d);
      compared++;
      if (dif.digit_en_n !== exp_en || dif.segment_n !== segs[d]) begin
        mismatched++;
        $display("[TB] FAIL scan_c%0d: got en=%b seg=%b want %b %b",
                 c, dif.digit_en_n, dif.segment_n, exp_en, segs[d]);
      end
    end
  endtask

  task automatic test_blink();
    dif.show_time = 0; dif.show_alarm = 0;
    dif.set_data = 16'h0959; dif.blink_mask = 4'b0011;
    pulse_second();
    wait_digit(0, "blink_d0");
    compared++;
    if (dif.segment_n !== PB) begin
      mismatched++; $display("[TB] FAIL blink_d0: got %b want %b", dif.segment_n, PB);
    end
    wait_digit(1, "blink_d1");
    compared++;
    if (dif.segment_n !== PB) begin
      mismatched++; $display("[TB] FAIL blink_d1: got %b want %b", dif.segment_n, PB);
    end
    wait_digit(2, "blink_d2");
    compared++;
    if (dif.segment_n !== P9) begin
      mismatched++; $display("[TB] FAIL blink_d2: got %b want %b", dif.segment_n, P9);
    end
    wait_digit(3, "blink_d3");
    compared++;
    if (dif.segment_n !== P0) begin
      mismatched++; $display("[TB] FAIL blink_d3: got %b want %b", dif.segment_n, P0);
    end
    dif.alarm_data = 16'h0959; dif.show_alarm = 1;
    wait_digit(0, "noblink_alarm");
    compared++;
    if (dif.segment_n !== P9) begin
      mismatched++; $display("[TB] FAIL noblink_alarm: got %b want %b", dif.segment_n, P9);
    end
    dif.show_alarm = 0;
    pulse_second();
    wait_digit(0, "unblink_d0");
    compared++;
    if (dif.segment_n !== P9) begin
      mismatched++; $display("[TB] FAIL unblink_d0: got %b want %b", dif.segment_n, P9);
    end
    wait_digit(1, "unblink_d1");
    compared++;
    if (dif.segment_n !== P5) begin
      mismatched++; $display("[TB] FAIL unblink_d1: got %b want %b", dif.segment_n, P5);
    end
  endtask

  task automatic test_blank_nibble();
    dif.alarm_on = 0; dif.show_time = 1; dif.time_data = 16'h12A4;
    wait_digit(1, "nibble_a");
    compared++;
    if (dif.segment_n !== PB) begin
      mismatched++; $display("[TB] FAIL nibble_a: got %b want %b", dif.segment_n, PB);
    end
    wait_digit(2, "nibble_2");
    compared++;
    if (dif.segment_n !== P2) begin
      mismatched++; $display("[TB] FAIL nibble_2: got %b want %b", dif.segment_n, P2);
    end
  endtask

  task automatic test_alarm();
    dif.show_time = 1; dif.alarm_data = 16'h0700; dif.time_data = 16'h0700;
    dif.stop_alarm = 0; dif.alarm_on = 1;
    compared++;
    if (dif.sound_alarm !== 1'b0) begin
      mismatched++; $display("[TB] FAIL alarm_pre: got %b want 0", dif.sound_alarm);
    end
    step(1);
    compared++;
    if (dif.sound_alarm !== 1'b1) begin
      mismatched++; $display("[TB] FAIL alarm_rise: got %b want 1", dif.sound_alarm);
    end
    pulse_second();
    pulse_second();
    compared++;
    if (dif.sound_alarm !== 1'b1) begin
      mismatched++; $display("[TB] FAIL alarm_2s: got %b want 1", dif.sound_alarm);
    end
    pulse_second();
    compared++;
    if (dif.sound_alarm !== 1'b0) begin
      mismatched++; $display("[TB] FAIL alarm_timeout: got %b want 0", dif.sound_alarm);
    end
    step(3);
    compared++;
    if (dif.sound_alarm !== 1'b0) begin
      mismatched++; $display("[TB] FAIL alarm_no_retrigger: got %b want 0", dif.sound_alarm);
    end
    dif.time_data = 16'h0701;
    step(1);
    dif.time_data = 16'h0700;
    step(1);
    compared++;
    if (dif.sound_alarm !== 1'b1) begin
      mismatched++; $display("[TB] FAIL alarm_rearm: got %b want 1", dif.sound_alarm);
    end
  endtask

  task automatic test_stop_and_off();
    dif.stop_alarm = 1;
    step(1);
    dif.stop_alarm = 0;
    compared++;
    if (dif.sound_alarm !== 1'b0) begin
      mismatched++; $display("[TB] FAIL stop_silences: got %b want 0", dif.sound_alarm);
    end
    step(2);
    compared++;
    if (dif.sound_alarm !== 1'b0) begin
      mismatched++; $display("[TB] FAIL stop_holds: got %b want 0", dif.sound_alarm);
    end
    dif.alarm_on = 0;
    step(1);
    dif.alarm_on = 1;
    step(1);
    compared++;
    if (dif.sound_alarm !== 1'b1) begin
      mismatched++; $display("[TB] FAIL rearm_after_off: got %b want 1", dif.sound_alarm);
    end
    dif.alarm_on = 0; dif.stop_alarm = 1; dif.one_second = 1;
    step(1);
    dif.one_second = 0; dif.stop_alarm = 0;
    compared++;
    if (dif.sound_alarm !== 1'b0) begin
      mismatched++; $display("[TB] FAIL off_priority: got %b want 0", dif.sound_alarm);
    end
    dif.alarm_on = 1;
    step(1);
    compared++;
    if (dif.sound_alarm !== 1'b1) begin
      mismatched++; $display("[TB] FAIL off_went_idle: got %b want 1", dif.sound_alarm);
    end
    dif.alarm_on = 0;
    step(1);
    dif.alarm_on = 1; dif.stop_alarm = 1;
    step(1);
    dif.stop_alarm = 0;
    step(1);
    compared++;
    if (dif.sound_alarm !== 1'b0) begin
      mismatched++; $display("[TB] FAIL idle_stop_silenced: got %b want 0", dif.sound_alarm);
    end
    dif.alarm_on = 0;
    step(1);
  endtask

  task automatic test_fast_scan();
    logic [3:0] exp_en [4];
    logic [6:0] exp_seg [4];
    bit         found;
    exp_en[0] = 4'b1101; exp_en[1] = 4'b1011; exp_en[2] = 4'b0111; exp_en[3] = 4'b1110;
    exp_seg[0] = P3; exp_seg[1] = P2; exp_seg[2] = P1; exp_seg[3] = P4;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (dif2.digit_en_n === 4'b1110) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL fast_timeout: digit_en_n=%b never reached 1110", dif2.digit_en_n);
    end
    for (int k = 0; k < 4; k++) begin
      step(1);
      compared++;
      if (dif2.digit_en_n !== exp_en[k] || dif2.segment_n !== exp_seg[k]) begin
        mismatched++;
        $display("[TB] FAIL fast_step%0d: got en=%b seg=%b want %b %b",
                 k, dif2.digit_en_n, dif2.segment_n, exp_en[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    dif.show_time = 1; dif.time_data = 16'h0700; dif.alarm_data = 16'h0700;
    dif.stop_alarm = 0; dif.alarm_on = 1;
    step(1);
    compared++;
    if (dif.sound_alarm !== 1'b1) begin
      mismatched++; $display("[TB] FAIL mid_ringing: got %b want 1", dif.sound_alarm);
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (dif.sound_alarm !== 1'b0 || dif.digit_en_n !== 4'b1111 || dif.segment_n !== PB ||
        dif2.digit_en_n !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_async: got snd=%b en=%b seg=%b en2=%b want 0 1111 1111111 1111",
               dif.sound_alarm, dif.digit_en_n, dif.segment_n, dif2.digit_en_n);
    end
    dif.alarm_on = 0;
    step(2);
    reset = 1'b0;
    step(1);
    compared++;
    if (dif.digit_en_n !== 4'b1110 || dif.segment_n !== P0 || dif.sound_alarm !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_release: got en=%b seg=%b snd=%b want 1110 %b 0",
               dif.digit_en_n, dif.segment_n, dif.sound_alarm, P0);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_blank_nibble();
    test_alarm();
    test_stop_and_off();
    test_fast_scan();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
